div_rem_iter: RTL and testbench

DIV_REM_ITER -- requirements
Module: div_rem_iter

---
 rtl/div_rem_iter.sv | 151 +++++++++++++++
 tb/tb_div_rem_iter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_rem_iter.sv
// Iterative RISC-V M-extension divider: one restoring quotient bit per cycle,
// with divide-by-zero and signed-overflow results produced on the accept edge.
module div_rem_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ce_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic [XLEN-1:0] result_o,
    output logic            ready_o,
    output logic [1:0]      status_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            ready_q, ready_d;

    logic            op_signed;
    logic [XLEN-1:0] rs1_mag;
    logic [XLEN-1:0] rs2_mag;
    logic [XLEN+1:0] trial;

    assign op_signed = ~op_i[0];
    assign rs1_mag   = (op_signed && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    assign rs2_mag   = (op_signed && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
    // Shift in the next dividend bit and try subtracting the divisor; a set
    // top bit means the subtraction went negative and must be discarded.
    assign trial     = {rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (ce_i) begin
                    op_d = op_i;
                    if (rs2_i == '0) begin
                        result_d = op_i[1] ? rs1_i : ALL_ONES;
                        state_d  = S_DONE;
                    end else if (op_signed && rs1_i == INT_MIN && rs2_i == ALL_ONES) begin
                        result_d = op_i[1] ? '0 : rs1_i;
                        state_d  = S_DONE;
                    end else begin
                        quo_d   = rs1_mag;
                        dvs_d   = rs2_mag;
                        rem_d   = '0;
                        cnt_d   = '0;
                        q_neg_d = rs1_i[XLEN-1] ^ rs2_i[XLEN-1];
                        r_neg_d = rs1_i[XLEN-1];
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!ce_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (!trial[XLEN+1]) begin
                        rem_d = trial[XLEN:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                if (!ce_i) begin
                    state_d = S_IDLE;
                end else begin
                    // Recorded signs only matter for the signed flavours.
                    if (op_q[1]) begin
                        result_d = (r_neg_q && !op_q[0]) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
                    end else begin
                        result_d = (q_neg_q && !op_q[0]) ? -quo_q : quo_q;
                    end
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign status_o = state_q;

endmodule

// File: tb/tb_div_rem_iter.sv
// Self-checking bench for div_rem_iter: scoreboard of expected results and
// latencies, pushed when an operation is driven and popped when ready_o rises.
module tb_div_rem_iter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ce;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] result;
    logic            ready;
    logic [1:0]      status;

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;
        string           name;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    div_rem_iter #(.XLEN(XLEN)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .ce_i     (ce),
        .op_i     (op),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .result_o (result),
        .ready_o  (ready),
        .status_o (status)
    );

    always #5 clk = ~clk;

    // Reference behaviour straight from RISC-V M semantics.
    function automatic logic [XLEN-1:0] ref_res(input logic [1:0] o, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sbv;
        sa  = a;
        sbv = b;
        if (b == 0) return o[1] ? a : '1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? '0 : a;
        case (o)
            2'd0:    return sa / sbv;
            2'd1:    return a / b;
            2'd2:    return sa % sbv;
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        if (b == 0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    // Drive one operation from IDLE, count edges (accept edge = 1) until ready_o,
    // scramble inputs while busy, then drop ce and let DONE return to IDLE.
    task automatic issue(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp_res, input int exp_lat, input string nm,
                         output logic [XLEN-1:0] got, output int lat);
        exp_t e;
        e.res  = exp_res;
        e.lat  = exp_lat;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        ce  = 1'b1;
        op  = o;
        rs1 = a;
        rs2 = b;
        lat = 0;
        got = 'x;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready) begin
                got = result;
                break;
            end
            op  = 2'($urandom);
            rs1 = $urandom;
            rs2 = $urandom;
        end
        if (!ready) lat = -1;
        ce = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce  = 1'b0;
        op  = 2'b00;
        rs1 = '0;
        rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (result !== 32'h0) $display("FAIL reset_result got=%h exp=%h", result, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ready);
        else pass_cnt++;
        total_cnt++;
        if (status !== 2'b00) $display("FAIL reset_status got=%b exp=00", status);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        $display("reset: result=%h ready=%b status=%b", result, ready, status);
    endtask

    task automatic test_status_seq();
        logic [1:0] exp_st;
        int         st_err = 0;
        int         rdy_err = 0;
        logic [XLEN-1:0] got = 'x;
        exp_t       e;
        e.res  = 32'd2;
        e.lat  = 34;
        e.name = "remu_100_7_seq";
        sb.push_back(e);
        @(negedge clk);
        ce  = 1'b1;
        op  = 2'b11;
        rs1 = 32'd100;
        rs2 = 32'd7;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk);
            #1;
            exp_st = (k <= 32) ? 2'b01 : (k == 33) ? 2'b10 : (k == 34) ? 2'b11 : 2'b00;
            if (status !== exp_st) st_err++;
            if (ready !== (k == 34)) rdy_err++;
            if (k == 34) begin
                got = result;
                ce  = 1'b0;
            end
        end
        e = sb.pop_front();
        total_cnt++;
        if (got !== e.res) $display("FAIL %s result got=%h exp=%h", e.name, got, e.res);
        else pass_cnt++;
        total_cnt++;
        if (st_err != 0) $display("FAIL status_seq bad_edges=%0d exp=0", st_err);
        else pass_cnt++;
        total_cnt++;
        if (rdy_err != 0) $display("FAIL ready_pulse bad_edges=%0d exp=0 (high only at edge 34)", rdy_err);
        else pass_cnt++;
        $display("status_seq: REMU 100,7 result=%h status_errs=%0d ready_errs=%0d", got, st_err, rdy_err);
    endtask

    task automatic test_vectors();
        logic [1:0]      v_op  [9];
        logic [XLEN-1:0] v_a   [9];
        logic [XLEN-1:0] v_b   [9];
        logic [XLEN-1:0] v_res [9];
        int              v_lat [9];
        logic [XLEN-1:0] got;
        int              lat;
        exp_t            e;
        v_op[0] = 2'b10; v_a[0] = 32'hFFFF_FFF9; v_b[0] = 32'd2;          v_res[0] = 32'hFFFF_FFFF; v_lat[0] = 34;
        v_op[1] = 2'b00; v_a[1] = 32'hFFFF_FFF9; v_b[1] = 32'd2;          v_res[1] = 32'hFFFF_FFFD; v_lat[1] = 34;
        v_op[2] = 2'b01; v_a[2] = 32'hFFFF_FFFF; v_b[2] = 32'd1;          v_res[2] = 32'hFFFF_FFFF; v_lat[2] = 34;
        v_op[3] = 2'b01; v_a[3] = 32'd5;         v_b[3] = 32'd0;          v_res[3] = 32'hFFFF_FFFF; v_lat[3] = 1;
        v_op[4] = 2'b11; v_a[4] = 32'd5;         v_b[4] = 32'd0;          v_res[4] = 32'd5;         v_lat[4] = 1;
        v_op[5] = 2'b00; v_a[5] = 32'h8000_0000; v_b[5] = 32'hFFFF_FFFF; v_res[5] = 32'h8000_0000; v_lat[5] = 1;
        v_op[6] = 2'b10; v_a[6] = 32'h8000_0000; v_b[6] = 32'hFFFF_FFFF; v_res[6] = 32'h0;         v_lat[6] = 1;
        v_op[7] = 2'b10; v_a[7] = 32'd7;         v_b[7] = 32'hFFFF_FFFE; v_res[7] = 32'd1;         v_lat[7] = 34;
        v_op[8] = 2'b01; v_a[8] = 32'h8000_0000; v_b[8] = 32'hFFFF_FFFF; v_res[8] = 32'h0;         v_lat[8] = 34;
        for (int i = 0; i < 9; i++) begin
            issue(v_op[i], v_a[i], v_b[i], v_res[i], v_lat[i], $sformatf("vec%0d", i), got, lat);
            e = sb.pop_front();
            total_cnt++;
            if (got !== e.res) $display("FAIL %s result got=%h exp=%h", e.name, got, e.res);
            else pass_cnt++;
            total_cnt++;
            if (lat != e.lat) $display("FAIL %s latency got=%0d exp=%0d", e.name, lat, e.lat);
            else pass_cnt++;
            $display("%s: op=%b a=%h b=%h result=%h lat=%0d", e.name, v_op[i], v_a[i], v_b[i], got, lat);
        end
    endtask

    task automatic test_random();
        logic [1:0]      o;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] got;
        int              lat;
        exp_t            e;
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom);
            a = $urandom;
            b = $urandom;
            if (i % 4 == 1) b = $urandom_range(1, 15);
            if (i % 4 == 2) b = -$urandom_range(1, 15);
            if (i == 7) b = '0;
            issue(o, a, b, ref_res(o, a, b), ref_lat(o, a, b), $sformatf("rand%0d", i), got, lat);
            e = sb.pop_front();
            total_cnt++;
            if (got !== e.res) $display("FAIL %s result got=%h exp=%h", e.name, got, e.res);
            else pass_cnt++;
            total_cnt++;
            if (lat != e.lat) $display("FAIL %s latency got=%0d exp=%0d", e.name, lat, e.lat);
            else pass_cnt++;
            $display("%s: op=%b a=%h b=%h result=%h lat=%0d", e.name, o, a, b, got, lat);
        end
    endtask

    task automatic test_abort();
        logic [XLEN-1:0] got;
        int              lat;
        int              rdy_seen = 0;
        exp_t            e;
        issue(2'b01, 32'd100, 32'd3, 32'd33, 34, "abort_pre", got, lat);
        e = sb.pop_front();
        total_cnt++;
        if (got !== e.res) $display("FAIL %s result got=%h exp=%h", e.name, got, e.res);
        else pass_cnt++;
        @(negedge clk);
        ce  = 1'b1;
        op  = 2'b01;
        rs1 = 32'd1000;
        rs2 = 32'd3;
        repeat (10) @(posedge clk);
        @(negedge clk);
        ce = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (status !== 2'b00) $display("FAIL abort_status got=%b exp=00", status);
        else pass_cnt++;
        total_cnt++;
        if (result !== 32'd33) $display("FAIL abort_result got=%h exp=%h", result, 32'd33);
        else pass_cnt++;
        for (int k = 0; k < 40; k++) begin
            if (ready) rdy_seen++;
            @(posedge clk);
            #1;
        end
        total_cnt++;
        if (rdy_seen != 0) $display("FAIL abort_ready got=%0d cycles high exp=0", rdy_seen);
        else pass_cnt++;
        $display("abort: status=%b result=%h ready_cycles=%0d", status, result, rdy_seen);
    endtask

    task automatic test_reset_mid();
        logic [XLEN-1:0] got;
        int              lat;
        exp_t            e;
        @(negedge clk);
        ce  = 1'b1;
        op  = 2'b00;
        rs1 = -32'd100;
        rs2 = 32'd7;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (result !== 32'h0) $display("FAIL midrst_result got=%h exp=0", result);
        else pass_cnt++;
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL midrst_ready got=%b exp=0", ready);
        else pass_cnt++;
        total_cnt++;
        if (status !== 2'b00) $display("FAIL midrst_status got=%b exp=00", status);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b0;
        issue(2'b11, 32'd9, 32'd4, 32'd1, 34, "remu_9_4", got, lat);
        e = sb.pop_front();
        total_cnt++;
        if (got !== e.res) $display("FAIL %s result got=%h exp=%h", e.name, got, e.res);
        else pass_cnt++;
        total_cnt++;
        if (lat != e.lat) $display("FAIL %s latency got=%0d exp=%0d", e.name, lat, e.lat);
        else pass_cnt++;
        $display("reset_mid: then REMU 9,4 result=%h lat=%0d", got, lat);
    endtask

    task automatic test_back_to_back();
        logic [XLEN-1:0] got [2];
        int              lat [2];
        exp_t            e;
        e.res = 32'hFFFF_FFF9; e.lat = 34; e.name = "b2b_div";
        sb.push_back(e);
        e.res = 32'hFFFF_FFFF; e.lat = 34; e.name = "b2b_rem";
        sb.push_back(e);
        @(negedge clk);
        ce  = 1'b1;
        op  = 2'b00;
        rs1 = -32'd50;
        rs2 = 32'd7;
        for (int n = 0; n < 2; n++) begin
            lat[n] = -1;
            got[n] = 'x;
            for (int k = 1; k < 100; k++) begin
                @(posedge clk);
                #1;
                if (ready) begin
                    lat[n] = k;
                    got[n] = result;
                    break;
                end
            end
            if (n == 0) begin
                // ce stays high: DONE must still pass through IDLE before re-accepting.
                @(posedge clk);
                #1;
                total_cnt++;
                if (status !== 2'b00 || ready !== 1'b0)
                    $display("FAIL b2b_idle got status=%b ready=%b exp status=00 ready=0", status, ready);
                else pass_cnt++;
                op = 2'b10;
            end
        end
        ce = 1'b0;
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++) begin
            e = sb.pop_front();
            total_cnt++;
            if (got[n] !== e.res) $display("FAIL %s result got=%h exp=%h", e.name, got[n], e.res);
            else pass_cnt++;
            total_cnt++;
            if (lat[n] != e.lat) $display("FAIL %s latency got=%0d exp=%0d", e.name, lat[n], e.lat);
            else pass_cnt++;
            $display("%s: result=%h lat=%0d", e.name, got[n], lat[n]);
        end
    endtask

    initial begin
        test_reset();
        test_status_seq();
        test_vectors();
        test_random();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
